// File: rtl/approx_adder_pkg.sv
// Shared types and constants for the sequential approximate adder.
// Optional statistics (op/err counters) are enabled by the APPROX_ERR_STATS_EN macro.
package approx_adder_pkg;

    // Control FSM states
    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Width of the statistics counters
    localparam int unsigned CNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/approx_slice.sv
// One SLICE_W-bit adder slice: exact ripple add, or OR-based approximation
// where the carry-out is predicted from the two operand MSBs alone.
module approx_slice #(
    parameter int unsigned SLICE_W = 8
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    input  logic               approx,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W:0] full;

    // Pick exact or approximate slice result; incoming carry is ignored when approximating
    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
        if (approx) begin
            sum  = a | b;
            cout = a[SLICE_W-1] & b[SLICE_W-1];
        end else begin
            sum  = full[SLICE_W-1:0];
            cout = full[SLICE_W];
        end
    end

endmodule

// File: rtl/approx_adder_seq.sv
// Multi-cycle adder: one SLICE_W slice per cycle, LSB first, optional approximation
// of the lowest APPROX_SLICES slices. Operands shift right as slices are consumed and
// the result shifts in from the top, so a single slice instance serves every cycle.
// Macro APPROX_ERR_STATS_EN adds a shadow exact chain plus op/err statistics counters.
module approx_adder_seq
    import approx_adder_pkg::*;
#(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned SLICE_W       = 8,
    parameter int unsigned APPROX_SLICES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_approx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic [CNT_W-1:0] op_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned IDX_W  = $clog2(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_e state_q, state_d;

    logic [WIDTH-1:0]   a_q, b_q, sum_q;
    logic               approx_q, carry_q, cout_q;
    logic [IDX_W-1:0]   idx_q;
    logic               accept, step, finish;
    logic [SLICE_W-1:0] sl_sum;
    logic               sl_cout, sl_approx;

    // Only the lowest APPROX_SLICES slices are approximated, and only in approx mode
    assign sl_approx = approx_q && (32'(idx_q) < APPROX_SLICES);
    assign finish    = step && (idx_q == LAST_IDX);

    approx_slice #(
        .SLICE_W(SLICE_W)
    ) u_slice (
        .a     (a_q[SLICE_W-1:0]),
        .b     (b_q[SLICE_W-1:0]),
        .cin   (carry_q),
        .approx(sl_approx),
        .sum   (sl_sum),
        .cout  (sl_cout)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                step = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Operand capture and slice-serial datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            approx_q <= 1'b0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            idx_q    <= '0;
        end else if (accept) begin
            a_q      <= in_a;
            b_q      <= in_b;
            carry_q  <= in_cin;
            approx_q <= in_approx;
            idx_q    <= '0;
        end else if (step) begin
            a_q     <= a_q >> SLICE_W;
            b_q     <= b_q >> SLICE_W;
            sum_q   <= {sl_sum, sum_q[WIDTH-1:SLICE_W]};
            carry_q <= sl_cout;
            idx_q   <= idx_q + IDX_W'(1);
            if (finish) begin
                cout_q <= sl_cout;
            end
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;

`ifdef APPROX_ERR_STATS_EN
    logic [WIDTH-1:0] ex_sum_q;
    logic             ex_carry_q;
    logic [SLICE_W:0] ex_full;
    logic [CNT_W-1:0] op_cnt_q, err_cnt_q;
    logic             mismatch;

    assign ex_full = {1'b0, a_q[SLICE_W-1:0]} + {1'b0, b_q[SLICE_W-1:0]}
                   + {{SLICE_W{1'b0}}, ex_carry_q};

    // Compare the full result as it will look on entry to DONE
    assign mismatch = {sl_cout, sl_sum, sum_q[WIDTH-1:SLICE_W]}
                   != {ex_full[SLICE_W], ex_full[SLICE_W-1:0], ex_sum_q[WIDTH-1:SLICE_W]};

    // Shadow exact chain and saturating statistics, updated on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_sum_q   <= '0;
            ex_carry_q <= 1'b0;
            op_cnt_q   <= '0;
            err_cnt_q  <= '0;
        end else if (accept) begin
            ex_carry_q <= in_cin;
        end else if (step) begin
            ex_sum_q   <= {ex_full[SLICE_W-1:0], ex_sum_q[WIDTH-1:SLICE_W]};
            ex_carry_q <= ex_full[SLICE_W];
            if (finish) begin
                if (approx_q) begin
                    op_cnt_q <= sat_inc(op_cnt_q);
                end
                if (mismatch) begin
                    err_cnt_q <= sat_inc(err_cnt_q);
                end
            end
        end
    end

    assign op_cnt  = op_cnt_q;
    assign err_cnt = err_cnt_q;
`else
    assign op_cnt  = '0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_approx_adder_seq.sv
// Scoreboard bench for approx_adder_seq: a driver pushes expected results computed by
// a behavioural model; a monitor pops and compares on each output handshake.
module tb_approx_adder_seq;

    localparam int WIDTH  = 32;
    localparam int SW     = 8;
    localparam int NSLICE = WIDTH / SW;
    localparam int ASL    = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  in_a = '0;
    logic [WIDTH-1:0]  in_b = '0;
    logic              in_cin = 1'b0;
    logic              in_approx = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WIDTH-1:0]  out_sum;
    logic              out_cout;
    logic [15:0]       op_cnt, err_cnt;

    approx_adder_seq #(
        .WIDTH(WIDTH),
        .SLICE_W(SW),
        .APPROX_SLICES(ASL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .in_approx(in_approx),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .op_cnt   (op_cnt),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic [15:0]      op;
        logic [15:0]      err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_op  = 0;
    int   m_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Exact sum is plain wide addition; approx mode rebuilds it slice by slice
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic cin, input logic approx);
        logic [WIDTH-1:0] s;
        logic             c;
        logic [SW-1:0]    as, bs;
        logic [SW:0]      t;
        if (!approx) return {1'b0, a} + {1'b0, b} + (WIDTH + 1)'(cin);
        s = '0;
        c = cin;
        for (int k = 0; k < NSLICE; k++) begin
            as = a[k*SW +: SW];
            bs = b[k*SW +: SW];
            if (k < ASL) begin
                s[k*SW +: SW] = as | bs;
                c = as[SW-1] & bs[SW-1];
            end else begin
                t = {1'b0, as} + {1'b0, bs} + (SW + 1)'(c);
                s[k*SW +: SW] = t[SW-1:0];
                c = t[SW];
            end
        end
        return {c, s};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_sum"}, 64'(out_sum), 64'd0);
        check({tag, "_out_cout"}, 64'(out_cout), 64'd0);
        check({tag, "_op_cnt"}, 64'(op_cnt), 64'd0);
        check({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
    endtask

    // Issue one operation, check latency, hold the result for 'hold' cycles, then consume it
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                         input logic approx, input int hold, input bit noise);
        logic [WIDTH:0] r, ex;
        exp_t           e;
        int             lat, guard;
        logic [WIDTH-1:0] held_sum;
        logic           held_cout;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            check("wait_in_ready", 64'(in_ready), 64'd1);
            return;
        end
        in_a = a; in_b = b; in_cin = cin; in_approx = approx; in_valid = 1'b1;
        r  = model(a, b, cin, approx);
        ex = model(a, b, cin, 1'b0);
        if (approx && m_op < 16'hFFFF) m_op++;
        if (r != ex && m_err < 16'hFFFF) m_err++;
        e.sum  = r[WIDTH-1:0];
        e.cout = r[WIDTH];
`ifdef APPROX_ERR_STATS_EN
        e.op  = 16'(m_op);
        e.err = 16'(m_err);
`else
        e.op  = 16'd0;
        e.err = 16'd0;
`endif
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (noise) begin
                in_valid = 1'b1;
                in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom); in_approx = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check("latency", 64'(lat), 64'(NSLICE));
        held_sum  = out_sum;
        held_cout = out_cout;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_sum", {31'd0, out_cout, out_sum}, {31'd0, held_cout, held_sum});
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("back_to_idle", 64'(in_ready), 64'd1);
    endtask

    // Monitor: compare whenever a result is handed over
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'(out_valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum", {31'd0, out_cout, out_sum}, {31'd0, e.cout, e.sum});
                check("op_cnt", 64'(op_cnt), 64'(e.op));
                check("err_cnt", 64'(err_cnt), 64'(e.err));
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed corner cases
        do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
        do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1, 0, 1'b0);
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 5, 1'b0);
        do_op(32'h1234_5600, 32'h0000_0000, 1'b0, 1'b1, 0, 1'b0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1, 1'b1);

        // Abort mid-RUN: start an op that is never pushed, reset during its second RUN cycle
        in_a = 32'hDEAD_BEEF; in_b = 32'h0101_0101; in_cin = 1'b1; in_approx = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        m_op  = 0;
        m_err = 0;
        #2;
        check_reset_outputs("abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_idle", 64'(in_ready), 64'd1);
        do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);

        // Randomized operations, in_valid noise while busy
        for (int n = 0; n < 40; n++) begin
            do_op($urandom, $urandom, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                  1'($urandom));
        end

        @(posedge clk); #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
